// File: rtl/pipe_ctrl_if.sv
// Hazard/stall control bundle between the pipeline datapath and pipe_ctrl.
// stall_cycles exists only when PIPE_PERF_CNT_EN is defined.
interface pipe_ctrl_if;
    logic [4:0]  ID_EX_rd_hu;
    logic        mem_read_hu;
    logic [4:0]  IF_ID_rs1;
    logic [4:0]  IF_ID_rs2;
    logic        rs1_used;
    logic        rs2_used;
    logic        branch_taken;
    logic        dmem_req;
    logic        dmem_ready;
    logic        PC_en;
    logic        IF_ID_en;
    logic        ID_EX_en;
    logic        EX_MEM_en;
    logic        MEM_WB_en;
    logic        IF_ID_clr;
    logic        ID_EX_nop;
    logic        mem_err;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles;

    modport master (
        output ID_EX_rd_hu, mem_read_hu, IF_ID_rs1, IF_ID_rs2, rs1_used, rs2_used,
               branch_taken, dmem_req, dmem_ready,
        input  PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_clr, ID_EX_nop,
               mem_err, stall_cycles
    );
    modport slave (
        input  ID_EX_rd_hu, mem_read_hu, IF_ID_rs1, IF_ID_rs2, rs1_used, rs2_used,
               branch_taken, dmem_req, dmem_ready,
        output PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_clr, ID_EX_nop,
               mem_err, stall_cycles
    );
`else
    modport master (
        output ID_EX_rd_hu, mem_read_hu, IF_ID_rs1, IF_ID_rs2, rs1_used, rs2_used,
               branch_taken, dmem_req, dmem_ready,
        input  PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_clr, ID_EX_nop,
               mem_err
    );
    modport slave (
        input  ID_EX_rd_hu, mem_read_hu, IF_ID_rs1, IF_ID_rs2, rs1_used, rs2_used,
               branch_taken, dmem_req, dmem_ready,
        output PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_clr, ID_EX_nop,
               mem_err
    );
`endif
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: memory-wait freeze with timeout, branch flush, load-use bubble.
// Optional stall-cycle performance counter enabled by defining PIPE_PERF_CNT_EN.
module pipe_ctrl #(
    parameter int WAIT_MAX = 255
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   pif
);
    typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} state_t;

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    state_t      state;
    logic [7:0]  wcnt;
    logic        mem_err_q;
    logic        mem_err_now;
    logic        freeze;
    logic        load_use;
    logic        rs1_hit;
    logic        rs2_hit;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_q;
`endif

    always_comb begin
        mem_err_now = (state == MEM_WAIT) && (wcnt == WAIT_LIM);
        freeze      = pif.dmem_req && !pif.dmem_ready && !mem_err_now;
        rs1_hit     = pif.rs1_used && (pif.IF_ID_rs1 == pif.ID_EX_rd_hu);
        rs2_hit     = pif.rs2_used && (pif.IF_ID_rs2 == pif.ID_EX_rd_hu);
        load_use    = pif.mem_read_hu && (pif.ID_EX_rd_hu != '0) && (rs1_hit || rs2_hit);
    end

    // Priority: INIT > freeze > branch flush > load-use bubble > normal flow.
    always_comb begin
        pif.PC_en     = 1'b1;
        pif.IF_ID_en  = 1'b1;
        pif.ID_EX_en  = 1'b1;
        pif.EX_MEM_en = 1'b1;
        pif.MEM_WB_en = 1'b1;
        pif.IF_ID_clr = 1'b0;
        pif.ID_EX_nop = 1'b0;
        if (state == INIT || freeze) begin
            pif.PC_en     = 1'b0;
            pif.IF_ID_en  = 1'b0;
            pif.ID_EX_en  = 1'b0;
            pif.EX_MEM_en = 1'b0;
            pif.MEM_WB_en = 1'b0;
            pif.IF_ID_clr = (state == INIT);
            pif.ID_EX_nop = (state == INIT);
        end else if (pif.branch_taken) begin
            pif.IF_ID_clr = 1'b1;
            pif.ID_EX_nop = 1'b1;
        end else if (load_use) begin
            pif.PC_en     = 1'b0;
            pif.IF_ID_en  = 1'b0;
            pif.ID_EX_nop = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            wcnt      <= '0;
            mem_err_q <= 1'b0;
`ifdef PIPE_PERF_CNT_EN
            stall_q   <= '0;
`endif
        end else begin
            if (state == INIT) begin
                state <= RUN;
                wcnt  <= '0;
            end else begin
                state <= freeze ? MEM_WAIT : RUN;
                // Counting starts on the first MEM_WAIT cycle; RUN always leaves it at zero.
                wcnt  <= (state == MEM_WAIT && freeze) ? wcnt + 8'd1 : '0;
                if (mem_err_now && !pif.dmem_ready)
                    mem_err_q <= 1'b1;
`ifdef PIPE_PERF_CNT_EN
                if (!pif.PC_en || pif.ID_EX_nop)
                    stall_q <= stall_q + 32'd1;
`endif
            end
        end
    end

    assign pif.mem_err = mem_err_q;
`ifdef PIPE_PERF_CNT_EN
    assign pif.stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table plus randomized run against a reference model.
module tb_pipe_ctrl;
    localparam int WMAX = 4;

    localparam logic [6:0] O_INIT = 7'b0000011;
    localparam logic [6:0] O_NORM = 7'b1111100;
    localparam logic [6:0] O_FRZ  = 7'b0000000;
    localparam logic [6:0] O_BR   = 7'b1111111;
    localparam logic [6:0] O_LU   = 7'b0011101;

    typedef struct {
        logic       r;
        logic [4:0] rd;
        logic       mr;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       br;
        logic       dq;
        logic       dr;
        logic [6:0] eo;
        logic       er;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if pif();
    pipe_ctrl #(.WAIT_MAX(WMAX)) dut (.clk(clk), .rst(rst), .pif(pif));

    logic [6:0] act_o;
    assign act_o = {pif.PC_en, pif.IF_ID_en, pif.ID_EX_en, pif.EX_MEM_en, pif.MEM_WB_en,
                    pif.IF_ID_clr, pif.ID_EX_nop};

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    vec_t vecs[33];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic r, logic [4:0] rd, logic mr, logic [4:0] rs1, logic [4:0] rs2,
                                logic u1, logic u2, logic br, logic dq, logic dr,
                                logic [6:0] eo, logic er);
        vec_t v;
        v.r = r; v.rd = rd; v.mr = mr; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.br = br; v.dq = dq; v.dr = dr; v.eo = eo; v.er = er;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [4:0] rd, input logic mr, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2, input logic br,
                         input logic dq, input logic dr);
        rst              = r;
        pif.ID_EX_rd_hu  = rd;
        pif.mem_read_hu  = mr;
        pif.IF_ID_rs1    = rs1;
        pif.IF_ID_rs2    = rs2;
        pif.rs1_used     = u1;
        pif.rs2_used     = u2;
        pif.branch_taken = br;
        pif.dmem_req     = dq;
        pif.dmem_ready   = dr;
    endtask

    // Reference: timeout happens once WMAX+1 consecutive frozen cycles have elapsed.
    bit          m_init;
    int unsigned m_run;
    bit          m_err;
    logic [31:0] m_stall;

    initial begin
        logic [4:0] rd, rs1, rs2;
        logic r, mr, u1, u2, br, dq, dr, lu, frz, tmo;
        logic [6:0] eo;

        drive(1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_INIT, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_INIT, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_INIT, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0);
        vecs[4]  = mk(0, 5, 1, 0, 5, 0, 1, 0, 0, 0, O_LU,   0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0);
        vecs[6]  = mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, O_NORM, 0);
        vecs[7]  = mk(0, 7, 0, 7, 0, 1, 0, 0, 0, 0, O_NORM, 0);
        vecs[8]  = mk(0, 7, 1, 7, 7, 0, 0, 0, 0, 0, O_NORM, 0);
        vecs[9]  = mk(0, 5, 1, 0, 5, 0, 1, 1, 0, 0, O_BR,   0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NORM, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_FRZ,  0);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_FRZ,  0);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, O_BR,   0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0);
        for (int i = 19; i <= 23; i++)
            vecs[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ, 0);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_NORM, 0);
        vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 1);
        vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 1);
        vecs[27] = mk(0, 3, 1, 3, 0, 1, 0, 0, 0, 0, O_LU,   1);
        vecs[28] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  1);
        vecs[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  1);
        vecs[30] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_INIT, 0);
        vecs[31] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_INIT, 0);
        vecs[32] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].r, vecs[i].rd, vecs[i].mr, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].u1, vecs[i].u2, vecs[i].br, vecs[i].dq, vecs[i].dr);
            #1;
            check($sformatf("vec%0d_out", i), 32'(act_o), 32'(vecs[i].eo));
            check($sformatf("vec%0d_err", i), 32'(pif.mem_err), 32'(vecs[i].er));
        end

`ifdef PIPE_PERF_CNT_EN
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i < 2) drive(0, 5'd6, 1, 5'd6, 5'd0, 1, 0, 0, 0, 0);
            else       drive(0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0, 1, (i == 5));
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("perf_five", pif.stall_cycles, 32'd5);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1;
        check("perf_rst", pif.stall_cycles, 32'd0);
        check("perf_rst_out", 32'(act_o), 32'(O_INIT));
`endif

        m_init = 1'b1; m_run = 0; m_err = 1'b0; m_stall = '0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            r   = (c == 0) || ($urandom_range(0, 99) == 0);
            rd  = 5'($urandom_range(0, 3));
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            mr  = 1'($urandom_range(0, 1));
            u1  = 1'($urandom_range(0, 1));
            u2  = 1'($urandom_range(0, 1));
            br  = ($urandom_range(0, 4) == 0);
            dq  = ($urandom_range(0, 3) != 0);
            dr  = ($urandom_range(0, 5) == 0);
            drive(r, rd, mr, rs1, rs2, u1, u2, br, dq, dr);
            if (r) begin
                m_init = 1'b1; m_run = 0; m_err = 1'b0; m_stall = '0;
            end
            lu  = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
            tmo = !m_init && (m_run == WMAX + 1);
            frz = dq && !dr && !tmo;
            if (m_init)      eo = O_INIT;
            else if (frz)    eo = O_FRZ;
            else if (br)     eo = O_BR;
            else if (lu)     eo = O_LU;
            else             eo = O_NORM;
            #1;
            check("rnd_out", 32'(act_o), 32'(eo));
            check("rnd_err", 32'(pif.mem_err), 32'(m_err));
`ifdef PIPE_PERF_CNT_EN
            check("rnd_stall", pif.stall_cycles, m_stall);
`endif
            if (!r) begin
                if (m_init) begin
                    m_init = 1'b0;
                    m_run  = 0;
                end else begin
                    if (tmo && !dr) m_err = 1'b1;
                    if (!eo[6] || eo[0]) m_stall = m_stall + 32'd1;
                    m_run = frz ? m_run + 1 : 0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 255, memory-wait cycle limit before timeout; legal range 1..255.
REQ-002 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ID_EX_rd_hu  input  5  destination register of the instruction in EX.
REQ-005 mem_read_hu  input  1  instruction in EX is a load.
REQ-006 IF_ID_rs1, IF_ID_rs2  input  5 each  source registers of the instruction in ID.
REQ-007 rs1_used, rs2_used  input  1 each  the ID instruction reads rs1 / rs2.
REQ-008 branch_taken  input  1  a taken branch or jump is resolved in EX this cycle.
REQ-009 dmem_req  input  1  MEM stage holds a load or store.
REQ-010 dmem_ready  input  1  data memory completes the MEM access this cycle.
REQ-011 PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en  output  1 each  pipeline register load enables.
REQ-012 IF_ID_clr  output  1  clear IF/ID to NOP.
REQ-013 ID_EX_nop  output  1  select the NOP control word into ID/EX (bubble).
REQ-014 mem_err  output  1  sticky memory-timeout flag.
REQ-015 stall_cycles  output  32  frozen-or-bubbled cycle count (present only with PIPE_PERF_CNT_EN).

Function
REQ-016 The FSM SHALL have the states INIT, RUN and MEM_WAIT, plus an 8-bit wait counter wcnt.
REQ-017 INIT SHALL last exactly one cycle: all enables 0, IF_ID_clr=1, ID_EX_nop=1; then go to RUN.
REQ-018 Freeze condition F = dmem_req && !dmem_ready && !mem_err_now, where mem_err_now = (state==MEM_WAIT && wcnt==WAIT_MAX).
REQ-019 In RUN or MEM_WAIT, when F holds, all five enables SHALL be 0, IF_ID_clr=0 and ID_EX_nop=0; state goes to (or stays in) MEM_WAIT.
REQ-020 In MEM_WAIT, wcnt SHALL increment by 1 per frozen cycle; wcnt SHALL be cleared to 0 whenever the state is RUN.
REQ-021 In MEM_WAIT with wcnt==WAIT_MAX and dmem_ready still 0, mem_err SHALL set on the next edge, the freeze SHALL release that cycle, and the state SHALL return to RUN.
REQ-022 MEM_WAIT with dmem_ready=1 SHALL release the freeze in that same cycle and return to RUN.
REQ-023 When not frozen and branch_taken=1, the block SHALL assert IF_ID_clr=1 and ID_EX_nop=1, with all enables 1.
REQ-024 branch_taken SHALL be ignored while frozen; a held branch SHALL take effect in the first unfrozen cycle.
REQ-025 Load-use hazard L = mem_read_hu && ID_EX_rd_hu!=0 && ((rs1_used && IF_ID_rs1==ID_EX_rd_hu) || (rs2_used && IF_ID_rs2==ID_EX_rd_hu)).
REQ-026 When not frozen, branch_taken=0 and L=1: PC_en=0, IF_ID_en=0, ID_EX_nop=1, and ID_EX_en, EX_MEM_en and MEM_WB_en =1.
REQ-027 Priority SHALL be freeze > branch flush > load-use > normal flow (all enables 1, clr/nop 0).
REQ-028 All outputs except mem_err and stall_cycles SHALL be combinational from state, wcnt and inputs; mem_err SHALL clear only on reset.

Reset
REQ-029 rst SHALL force state=INIT, wcnt=0, mem_err=0 and stall_cycles=0 immediately, including in the middle of MEM_WAIT.
REQ-030 While rst=1, outputs SHALL equal the INIT values.

Configuration
REQ-031 With PIPE_PERF_CNT_EN defined, stall_cycles SHALL increment (wrapping at 2^32) on each cycle with PC_en=0 or ID_EX_nop=1, excluding INIT.
REQ-032 Without PIPE_PERF_CNT_EN, the stall_cycles port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Release rst -> the first cycle is INIT (IF_ID_clr=1, ID_EX_nop=1, enables 0); the second cycle is RUN with all enables 1.
REQ-034 mem_read_hu=1, ID_EX_rd_hu=5, IF_ID_rs2=5, rs2_used=1 -> one cycle with PC_en=0, IF_ID_en=0, ID_EX_nop=1; rd=0 -> no stall.
REQ-035 dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> enables 0 for 3 cycles, all 1 in the ready cycle; mem_err stays 0.
REQ-036 WAIT_MAX=4, dmem_ready held 0 -> freeze releases after the wait count reaches 4; mem_err=1 from the next edge; it stays set until rst.
REQ-037 branch_taken=1 together with L=1 -> IF_ID_clr=1, ID_EX_nop=1, PC_en=1; branch_taken=1 during a freeze -> flush occurs only in the release cycle.
REQ-038 With PIPE_PERF_CNT_EN: 2 load-use bubbles plus a 3-cycle freeze -> stall_cycles=5; assert rst mid-freeze -> stall_cycles=0 and state=INIT immediately.
